sbus_arbiter: RTL and testbench
===============================

Name: sbus_arbiter

Overview:
- Shares one downstream memory port between the core's instruction bus (ibus) and data bus (dbus) sbus masters.
- Sits between the datapath's ibus/dbus sbus ports and the single-ported memory/bridge.
- Serialises requests with a fixed dbus-first priority plus an ibus anti-starvation limit.
- Returns read data and stall to each master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive dbus grants allowed while ibus waits before ibus is forced (1..15)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
i_en  input  1  ibus request valid; held with payload until stall low
i_we  input  1  ibus write enable
i_size  input  2  ibus access size (00 byte, 01 half, 10 word)
i_addr  input  ADDR_W  ibus address
i_wdata  input  DATA_W  ibus write data
i_rdata  output  DATA_W  ibus read data, registered
i_stall  output  1  ibus stall
d_en, d_we, d_size, d_addr, d_wdata, d_rdata, d_stall  same directions/widths  dbus master port
m_req  output  1  downstream request, held until m_ack
m_we  output  1  downstream write enable
m_size  output  2  downstream size
m_addr  output  ADDR_W  downstream address
m_wdata  output  DATA_W  downstream write data
m_rdata  input  DATA_W  downstream read data, valid with m_ack
m_ack  input  1  downstream completion, one-cycle pulse
perf_i_grants  output  32  ibus grant count (optional feature)
perf_d_grants  output  32  dbus grant count (optional feature)
perf_conflicts  output  32  cycles both pending, one waiting (optional feature)

Behaviour:
- Reset (async, rst=1):
  - state IDLE; m_req, m_we = 0; m_size, m_addr, m_wdata = 0.
  - i_rdata, d_rdata = 0; starvation counter = 0; response flags = 0; perf counters = 0.
  - Asserting rst mid-transaction drops m_req immediately; the pending transaction is abandoned and no response is delivered.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Sample i_en/d_en each cycle; pending = en & ~resp flag.
  - Only dbus pending -> GNT_D.
  - Only ibus pending -> GNT_I.
  - Both pending -> GNT_D, unless starve counter == STARVE_LIMIT, then GNT_I.
- Grant entry: payload (we, size, addr, wdata) registered from the chosen master; m_req = 1 from the next cycle.
- GNT_x: hold m_req and payload stable until m_ack = 1, then return to IDLE in the next cycle.
- Ack cycle:
  - Read (we=0): x_rdata <= m_rdata.
  - Write: x_rdata unchanged.
  - Set that port's one-cycle response flag.
- Stall: x_stall = x_en & ~x_resp_flag (combinational).
  - Stall falls in the cycle after m_ack; x_rdata is valid in that cycle and held until the next read completes.
- Minimum latency: en at cycle 0, m_req at cycle 1, m_ack at cycle 1 -> stall low and rdata valid at cycle 2.
- Back-to-back grants:
  - IDLE is visited for one cycle between grants.
  - A master whose response flag is high in IDLE is not re-granted that cycle.
- Starvation counter:
  - Increments on each dbus grant taken while ibus pending, saturating at STARVE_LIMIT.
  - Clears on any ibus grant.
  - STARVE_LIMIT=1 alternates strictly under contention.
- Abort: if x_en falls before grant, the request is dropped. If it falls after grant, the downstream transaction still completes:
  - the read result is discarded (x_rdata unchanged);
  - no response flag is set.
- Payload changes while stalled are a master protocol violation; the registered payload is used.
- m_ack outside GNT_x is ignored.

Optional Feature:
- Macro SBUS_ARB_PERF_EN.
- Defined: the three perf counters are live 32-bit wrap-around counters.
  - perf_i_grants / perf_d_grants increment on entry to GNT_I / GNT_D.
  - perf_conflicts increments each cycle both masters are pending and one is not granted.
- Undefined: counter logic is absent; the perf outputs are tied to 0.

Test Plan:
- Lone ibus read:
  - Stimulus: i_en=1, addr 0xBFC00000, m_ack at cycle 1 with m_rdata=0x3C080001.
  - Response: m_req only at cycle 1; i_stall 1 at cycles 0-1, 0 at cycle 2; i_rdata=0x3C080001.
- Simultaneous requests:
  - Stimulus: d_en store word 0x80000010 data 0xDEADBEEF, plus ibus read, both at cycle 0.
  - Response: dbus granted first (m_we=1, m_wdata=0xDEADBEEF); ibus granted after dbus completes; d_rdata unchanged.
- Starvation, STARVE_LIMIT=2:
  - Stimulus: dbus requests continuously, ibus held pending.
  - Response: grant order D, D, I, D, D, I.
- Abort:
  - Stimulus: ibus granted, i_en dropped before m_ack, m_rdata=0x12345678.
  - Response: transaction completes downstream; i_rdata keeps its old value; no stall glitch; next grant proceeds.
- Reset mid-op:
  - Stimulus: rst asserted while in GNT_D with m_req=1.
  - Response: m_req=0 in the same cycle; all outputs at reset values; after release, a new ibus read completes normally.
- SBUS_ARB_PERF_EN defined:
  - Stimulus: 3 ibus and 2 dbus grants, 1 conflict cycle.
  - Response: counters read 3, 2, 1.
  - Same stimulus with the macro undefined: all counters read 0.

Source files
------------

// File: rtl/sbus_arbiter.sv
// Two-master (ibus/dbus) sbus arbiter onto a single downstream memory port.
// Optional perf counters are built when SBUS_ARB_PERF_EN is defined.
module sbus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_en,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t            r_state, w_next;
  logic              r_req, r_we;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_i_rdata, r_d_rdata;
  logic              r_i_resp, r_d_resp;
  logic [3:0]        r_starve;

  logic w_i_pend, w_d_pend, w_gnt_i, w_gnt_d, w_done_i, w_done_d, w_conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         if (w_gnt_d) w_next = GNT_D;
                    else if (w_gnt_i) w_next = GNT_I;
      GNT_I, GNT_D: if (m_ack) w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  // dbus wins contention unless ibus has already lost STARVE_LIMIT times in a row
  always_comb begin
    w_i_pend   = i_en & ~r_i_resp;
    w_d_pend   = d_en & ~r_d_resp;
    w_gnt_d    = (r_state == IDLE) & w_d_pend & ~(w_i_pend & (r_starve == LP_LIMIT));
    w_gnt_i    = (r_state == IDLE) & w_i_pend & ~w_gnt_d;
    w_done_i   = (r_state == GNT_I) & m_ack;
    w_done_d   = (r_state == GNT_D) & m_ack;
    w_conflict = (r_state == IDLE) & w_i_pend & w_d_pend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_starve  <= '0;
    end else begin
      r_req <= (w_next != IDLE);
      if (w_gnt_d) begin
        r_we    <= d_we;
        r_size  <= d_size;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        if (w_i_pend && r_starve != LP_LIMIT) r_starve <= r_starve + 4'd1;
      end else if (w_gnt_i) begin
        r_we     <= i_we;
        r_size   <= i_size;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
        r_starve <= '0;
      end
      // A master that dropped en after grant gets neither data nor a response
      r_i_resp <= w_done_i & i_en;
      r_d_resp <= w_done_d & d_en;
      if (w_done_i && i_en && !r_we) r_i_rdata <= m_rdata;
      if (w_done_d && d_en && !r_we) r_d_rdata <= m_rdata;
    end
  end

  assign i_stall = i_en & ~r_i_resp;
  assign d_stall = d_en & ~r_d_resp;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign m_req   = r_req;
  assign m_we    = r_we;
  assign m_size  = r_size;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

`ifdef SBUS_ARB_PERF_EN
  logic [31:0] r_perf_i, r_perf_d, r_perf_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_i <= '0;
      r_perf_d <= '0;
      r_perf_c <= '0;
    end else begin
      if (w_gnt_i)    r_perf_i <= r_perf_i + 32'd1;
      if (w_gnt_d)    r_perf_d <= r_perf_d + 32'd1;
      if (w_conflict) r_perf_c <= r_perf_c + 32'd1;
    end
  end

  assign perf_i_grants  = r_perf_i;
  assign perf_d_grants  = r_perf_d;
  assign perf_conflicts = r_perf_c;
`else
  logic w_unused_conflict;
  assign w_unused_conflict = w_conflict;
  assign perf_i_grants  = '0;
  assign perf_d_grants  = '0;
  assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_sbus_arbiter.sv
// Directed self-checking bench for sbus_arbiter (STARVE_LIMIT=2 instance).
module tb_sbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en, i_we, d_en, d_we;
  logic [1:0]  i_size, d_size, m_size;
  logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
  logic        i_stall, d_stall, m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;

  logic        auto_ack = 1'b0;
  logic        man_ack  = 1'b0;
  logic [31:0] man_rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  // Auto mode acks in the first m_req cycle with address-derived read data
  assign m_ack   = auto_ack ? m_req : man_ack;
  assign m_rdata = auto_ack ? {m_addr[15:0], 16'hA5A5} : man_rdata;

  sbus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_we(i_we), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_en(d_en), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // One isolated read with ack in the first m_req cycle
  task automatic lone_read(input logic is_d, input logic [31:0] addr, input logic [31:0] data);
    cyc();
    if (is_d) begin d_en = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = addr; end
    else      begin i_en = 1'b1; i_we = 1'b0; i_size = 2'b10; i_addr = addr; end
    mid();
    check("rd_c0_stall", is_d ? d_stall : i_stall, 32'd1);
    check("rd_c0_req", m_req, 32'd0);
    cyc();
    man_ack = 1'b1; man_rdata = data;
    mid();
    check("rd_c1_req", m_req, 32'd1);
    check("rd_c1_addr", m_addr, addr);
    check("rd_c1_stall", is_d ? d_stall : i_stall, 32'd1);
    cyc();
    man_ack = 1'b0; man_rdata = '0;
    mid();
    check("rd_c2_stall", is_d ? d_stall : i_stall, 32'd0);
    check("rd_c2_req", m_req, 32'd0);
    check("rd_c2_rdata", is_d ? d_rdata : i_rdata, data);
    cyc();
    if (is_d) d_en = 1'b0; else i_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    string       exp_ord;
    int unsigned n_gnt;
    logic        prev_req, done_i, done_d;

    i_en = 0; i_we = 0; i_size = '0; i_addr = '0; i_wdata = '0;
    d_en = 0; d_we = 0; d_size = '0; d_addr = '0; d_wdata = '0;

    mid();
    check("rst_req", m_req, 32'd0);
    check("rst_addr", m_addr, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_perf_i", perf_i_grants, 32'd0);
    cyc();
    rst = 1'b0;

    lone_read(1'b0, 32'hBFC0_0000, 32'h3C08_0001);

    // Simultaneous: dbus store wins, ibus read follows
    cyc();
    d_en = 1; d_we = 1; d_size = 2'b10; d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF;
    i_en = 1; i_we = 0; i_size = 2'b10; i_addr = 32'hBFC0_0004;
    mid();
    check("sim_c0_istall", i_stall, 32'd1);
    check("sim_c0_dstall", d_stall, 32'd1);
    cyc();
    man_ack = 1; man_rdata = 32'h5555_5555;
    mid();
    check("sim_d_req", m_req, 32'd1);
    check("sim_d_we", m_we, 32'd1);
    check("sim_d_addr", m_addr, 32'h8000_0010);
    check("sim_d_wdata", m_wdata, 32'hDEAD_BEEF);
    cyc();
    man_ack = 0;
    mid();
    check("sim_d_stall", d_stall, 32'd0);
    check("sim_d_rdata", d_rdata, 32'd0);
    check("sim_i_wait", i_stall, 32'd1);
    cyc();
    d_en = 0; man_ack = 1; man_rdata = 32'h1122_3344;
    mid();
    check("sim_i_req", m_req, 32'd1);
    check("sim_i_addr", m_addr, 32'hBFC0_0004);
    check("sim_i_we", m_we, 32'd0);
    cyc();
    man_ack = 0;
    mid();
    check("sim_i_stall", i_stall, 32'd0);
    check("sim_i_rdata", i_rdata, 32'h1122_3344);
    cyc();
    i_en = 0;

    // Starvation: both re-request after every response cycle
    exp_ord = "DDIDDI";
    n_gnt = 0; prev_req = 0;
    auto_ack = 1;
    i_addr = 32'h1000; d_addr = 32'h2000; i_we = 0; d_we = 0;
    for (int c = 0; c < 60 && n_gnt < 6; c++) begin
      cyc();
      if (i_en && d_en && (!i_stall || !d_stall)) begin i_en = 0; d_en = 0; end
      else begin i_en = 1; d_en = 1; end
      mid();
      if (m_req && !prev_req) begin
        check($sformatf("starve_g%0d", n_gnt), (m_addr == 32'h1000) ? 32'h49 : 32'h44,
              {24'h0, exp_ord[n_gnt]});
        n_gnt++;
      end
      prev_req = m_req;
    end
    check("starve_ngrants", n_gnt, 32'd6);
    cyc();
    i_en = 0; d_en = 0;
    mid();
    check("starve_i_rdata", i_rdata, 32'h1000_A5A5);
    check("starve_d_rdata", d_rdata, 32'h2000_A5A5);
    auto_ack = 0;

    // Abort: ibus drops en after grant
    cyc();
    i_en = 1; i_we = 0; i_addr = 32'hBFC0_0100;
    mid();
    check("abt_c0_stall", i_stall, 32'd1);
    cyc();
    i_en = 0;
    mid();
    check("abt_c1_req", m_req, 32'd1);
    check("abt_c1_stall", i_stall, 32'd0);
    cyc();
    man_ack = 1; man_rdata = 32'h1234_5678;
    mid();
    check("abt_c2_req", m_req, 32'd1);
    cyc();
    man_ack = 0; man_rdata = '0;
    mid();
    check("abt_c3_req", m_req, 32'd0);
    check("abt_c3_stall", i_stall, 32'd0);
    check("abt_c3_rdata", i_rdata, 32'h1000_A5A5);
    lone_read(1'b1, 32'h8000_0020, 32'hCAFE_F00D);

    // Reset while GNT_D holds m_req
    cyc();
    d_en = 1; d_we = 1; d_size = 2'b10; d_addr = 32'h8000_0030; d_wdata = 32'h0102_0304;
    cyc();
    mid();
    check("rmo_req_pre", m_req, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rmo_req", m_req, 32'd0);
    check("rmo_we", m_we, 32'd0);
    check("rmo_size", m_size, 32'd0);
    check("rmo_addr", m_addr, 32'd0);
    check("rmo_wdata", m_wdata, 32'd0);
    check("rmo_i_rdata", i_rdata, 32'd0);
    check("rmo_d_rdata", d_rdata, 32'd0);
    d_en = 0;
    cyc();
    cyc();
    rst = 1'b0;
    lone_read(1'b0, 32'hBFC0_0200, 32'hA5A5_0001);

    // Perf: one contended pair, then one lone dbus and one lone ibus read
    auto_ack = 1; done_i = 0; done_d = 0;
    cyc();
    i_en = 1; d_en = 1; i_we = 0; d_we = 0; i_addr = 32'h1000; d_addr = 32'h2000;
    for (int c = 0; c < 12 && !(done_i && done_d); c++) begin
      cyc();
      if (d_en && !d_stall) begin d_en = 0; done_d = 1; end
      if (i_en && !i_stall) begin i_en = 0; done_i = 1; end
    end
    check("perf_pair_done", {30'd0, done_d, done_i}, 32'd3);
    auto_ack = 0;
    lone_read(1'b1, 32'h8000_0040, 32'h0BAD_F00D);
    lone_read(1'b0, 32'hBFC0_0300, 32'h0000_0042);
    mid();
`ifdef SBUS_ARB_PERF_EN
    check("perf_i", perf_i_grants, 32'd3);
    check("perf_d", perf_d_grants, 32'd2);
    check("perf_c", perf_conflicts, 32'd1);
`else
    check("perf_i", perf_i_grants, 32'd0);
    check("perf_d", perf_d_grants, 32'd0);
    check("perf_c", perf_conflicts, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
